// File: rtl/serial_adder_controller.sv
// -----------------------------------------------------------------------------
// serial_adder_controller
//
// Bit-serial, LSB-first adder with a three-state sequencer (IDLE, RUN, DONE).
// An accepted Start latches both operands. The block then performs one full-add
// per clock for DATA_WIDTH clocks. Each full-add uses two half-add stages and a
// carry flop. The finished sum and carry are then published in a single update.
//
// Timing, counting the accepting edge as edge 0:
//   edges 1..DATA_WIDTH   process bits 0..DATA_WIDTH-1
//   edge DATA_WIDTH       enters DONE and loads Sum_Out/Carry_Out
//   edge DATA_WIDTH+1     samples Done_Out high and returns to IDLE
//   edge DATA_WIDTH+2     is the earliest edge that can accept the next Start
//
// Parameters
//   DATA_WIDTH    operand width in bits, legal range 2..32 (default 8)
//
// Ports
//   Clock_In      in   1   clock, rising edge only
//   Reset_n_In    in   1   asynchronous active-low reset (release synchronised
//                          externally)
//   Start_In      in   1   request, sampled only in IDLE
//   Data_A_In     in   W   operand A, captured on an accepted Start
//   Data_B_In     in   W   operand B, captured on an accepted Start
//   Busy_Out      out  1   high whenever the FSM is not in IDLE
//   Done_Out      out  1   one-cycle completion pulse (the DONE state)
//   Sum_Out       out  W   registered (A+B) mod 2^W
//   Carry_Out     out  1   registered carry out of the MSB
//   Overflow_Out  out  1   registered two's-complement overflow; present only
//                          when SERIAL_ADDER_OVERFLOW_EN is defined
//
// Build option
//   SERIAL_ADDER_OVERFLOW_EN  adds Overflow_Out and its logic.
//
// State table
//   IDLE | waiting for Start_In; outputs hold the last result
//   RUN  | one serial full-add per edge, DATA_WIDTH edges in total
//   DONE | result published, Done_Out high; always returns to IDLE
// -----------------------------------------------------------------------------
module serial_adder_controller #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  Clock_In,
  input  logic                  Reset_n_In,
  input  logic                  Start_In,
  input  logic [DATA_WIDTH-1:0] Data_A_In,
  input  logic [DATA_WIDTH-1:0] Data_B_In,
  output logic                  Busy_Out,
  output logic                  Done_Out,
  output logic [DATA_WIDTH-1:0] Sum_Out,
  output logic                  Carry_Out
`ifdef SERIAL_ADDER_OVERFLOW_EN
  ,
  output logic                  Overflow_Out
`endif
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic                  load_ops;
  logic                  step;
  logic                  last_bit;

  logic [DATA_WIDTH-1:0] op_a_q;
  logic [DATA_WIDTH-1:0] op_b_q;
  logic [DATA_WIDTH-1:0] psum_q;
  logic [DATA_WIDTH-1:0] psum_next;
  logic [CNT_W-1:0]      cnt_q;
  logic                  carry_q;

  logic [DATA_WIDTH-1:0] sum_q;
  logic                  carry_out_q;

  logic ha0_sum, ha0_carry;
  logic ha1_sum, ha1_carry;
  logic fa_carry;

  // Two half adders and an OR form the full adder. The second stage folds in
  // the carry flop.
  always_comb begin
    ha0_sum   = op_a_q[0] ^ op_b_q[0];
    ha0_carry = op_a_q[0] & op_b_q[0];
    ha1_sum   = ha0_sum ^ carry_q;
    ha1_carry = ha0_sum & carry_q;
    fa_carry  = ha0_carry | ha1_carry;
  end

  // Each new bit enters at the MSB and shifts right. After DATA_WIDTH steps,
  // bit 0 of the result is in bit 0 of the register.
  assign psum_next = {ha1_sum, psum_q[DATA_WIDTH-1:1]};
  assign last_bit  = (cnt_q == LAST_BIT);

  always_ff @(posedge Clock_In or negedge Reset_n_In) begin
    if (!Reset_n_In) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    load_ops = 1'b0;
    step     = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start_In) begin
          load_ops = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last_bit) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Serial datapath: operand shifters, carry flop, bit counter, partial sum.
  always_ff @(posedge Clock_In or negedge Reset_n_In) begin
    if (!Reset_n_In) begin
      op_a_q  <= '0;
      op_b_q  <= '0;
      psum_q  <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
    end else if (load_ops) begin
      op_a_q  <= Data_A_In;
      op_b_q  <= Data_B_In;
      psum_q  <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
    end else if (step) begin
      op_a_q  <= op_a_q >> 1;
      op_b_q  <= op_b_q >> 1;
      psum_q  <= psum_next;
      cnt_q   <= cnt_q + CNT_W'(1);
      carry_q <= fa_carry;
    end
  end

  // Published result. It loads from the final step's combinational values, so
  // it changes exactly once, on the edge that enters DONE.
  always_ff @(posedge Clock_In or negedge Reset_n_In) begin
    if (!Reset_n_In) begin
      sum_q       <= '0;
      carry_out_q <= 1'b0;
    end else if (step && last_bit) begin
      sum_q       <= psum_next;
      carry_out_q <= fa_carry;
    end
  end

`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic overflow_q;

  // On the last step, carry_q holds the carry into the MSB and fa_carry holds
  // the carry out of it.
  always_ff @(posedge Clock_In or negedge Reset_n_In) begin
    if (!Reset_n_In) begin
      overflow_q <= 1'b0;
    end else if (step && last_bit) begin
      overflow_q <= carry_q ^ fa_carry;
    end
  end

  assign Overflow_Out = overflow_q;
`endif

  assign Busy_Out  = (state_q != IDLE);
  assign Done_Out  = (state_q == DONE);
  assign Sum_Out   = sum_q;
  assign Carry_Out = carry_out_q;

endmodule

// File: tb/tb_serial_adder_controller.sv
// -----------------------------------------------------------------------------
// Testbench for serial_adder_controller (DATA_WIDTH = 8).
// The bench keeps a transaction-level reference model. When an op is accepted,
// the model computes the whole sum with ordinary integer arithmetic. It then
// counts down the fixed latency. A comparator checks every DUT output against
// this model on every falling edge. Directed scenarios pin the model with
// literal values.
// -----------------------------------------------------------------------------
module tb_serial_adder_controller;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] da;
  logic [W-1:0] db;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic         ovf;
`endif

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 0;

  serial_adder_controller #(.DATA_WIDTH(W)) dut (
    .Clock_In   (clk),
    .Reset_n_In (rst_n),
    .Start_In   (start),
    .Data_A_In  (da),
    .Data_B_In  (db),
    .Busy_Out   (busy),
    .Done_Out   (done),
    .Sum_Out    (sum),
    .Carry_Out  (carry)
`ifdef SERIAL_ADDER_OVERFLOW_EN
    ,
    .Overflow_Out (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model. m_left counts the cycles left until the block is idle
  // again. An accepted op makes the block busy for W+1 cycles. The result
  // appears, together with Done, in the final busy cycle.
  int           m_left = 0;
  logic [W:0]   m_pend = '0;
  logic [W-1:0] m_sum  = '0;
  logic         m_c    = 1'b0;
  logic         m_ovf  = 1'b0;
  logic         m_pend_ovf = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0;
      m_sum  <= '0;
      m_c    <= 1'b0;
      m_ovf  <= 1'b0;
    end else if (m_left == 0) begin
      if (start) begin
        m_left     <= W + 1;
        m_pend     <= {1'b0, da} + {1'b0, db};
        m_pend_ovf <= (da[W-1] == db[W-1]) &&
                      ((da[W-1] ^ db[W-1] ^ ((({1'b0, da[W-2:0]} + {1'b0, db[W-2:0]}) >> (W-1)) != 0)) != da[W-1]);
      end
    end else begin
      m_left <= m_left - 1;
      if (m_left == 2) begin
        m_sum <= m_pend[W-1:0];
        m_c   <= m_pend[W];
        m_ovf <= m_pend_ovf;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_busy",  32'(busy),  32'(m_left != 0));
      chk("model_done",  32'(done),  32'(m_left == 1));
      chk("model_sum",   32'(sum),   32'(m_sum));
      chk("model_carry", 32'(carry), 32'(m_c));
`ifdef SERIAL_ADDER_OVERFLOW_EN
      chk("model_ovf",   32'(ovf),   32'(m_ovf));
`endif
    end
  end

  // Runs one op from IDLE. Done must read low 7 cycles after acceptance, read
  // high at the 8th (the value sampled by edge 9), and read low again after
  // that.
  task automatic lit_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_sum, input logic exp_c);
    @(negedge clk);
    start = 1'b1; da = a; db = b;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    chk({name, "_done_early"}, 32'(done), 32'd0);
    @(negedge clk);
    chk({name, "_done"},  32'(done),  32'd1);
    chk({name, "_sum"},   32'(sum),   32'(exp_sum));
    chk({name, "_carry"}, 32'(carry), 32'(exp_c));
    @(negedge clk);
    chk({name, "_done_after"}, 32'(done), 32'd0);
    chk({name, "_idle"},       32'(busy), 32'd0);
  endtask

  initial begin
    int done_cnt;
    int idle_cnt;
    start = 1'b0; da = '0; db = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("reset_busy",  32'(busy),  32'd0);
    chk("reset_done",  32'(done),  32'd0);
    chk("reset_sum",   32'(sum),   32'd0);
    chk("reset_carry", 32'(carry), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    lit_op("add_0f_01", 8'h0F, 8'h01, 8'h10, 1'b0);
    lit_op("add_ff_01", 8'hFF, 8'h01, 8'h00, 1'b1);
`ifdef SERIAL_ADDER_OVERFLOW_EN
    chk("ovf_ff_01", 32'(ovf), 32'd0);
`endif
    lit_op("add_7f_01", 8'h7F, 8'h01, 8'h80, 1'b0);
`ifdef SERIAL_ADDER_OVERFLOW_EN
    chk("ovf_7f_01", 32'(ovf), 32'd1);
`endif

    // Start held for 30 edges: ops are accepted every 10 edges, and Done is
    // seen 3 times. The block is idle for exactly 3 sampled cycles.
    @(negedge clk);
    start = 1'b1; da = 8'h12; db = 8'h34;
    done_cnt = 0; idle_cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) done_cnt++;
      if (!busy) idle_cnt++;
    end
    start = 1'b0;
    chk("held_done_count", 32'(done_cnt), 32'd3);
    chk("held_idle_count", 32'(idle_cnt), 32'd3);
    chk("held_sum",        32'(sum),      32'h46);

    // Reset asserted just before edge 4 of a run.
    @(negedge clk);
    start = 1'b1; da = 8'h55; db = 8'h2A;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy",  32'(busy),  32'd0);
    chk("midrst_done",  32'(done),  32'd0);
    chk("midrst_sum",   32'(sum),   32'd0);
    chk("midrst_carry", 32'(carry), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    chk("midrst_no_done", 32'(done_cnt), 32'd0);
    lit_op("after_rst", 8'h55, 8'h2A, 8'h7F, 1'b0);

    // Operands scrambled every cycle after acceptance.
    @(negedge clk);
    start = 1'b1; da = 8'h9C; db = 8'h8B;
    @(negedge clk);
    start = 1'b0;
    repeat (8) begin
      @(negedge clk);
      da = W'($urandom);
      db = W'($urandom);
    end
    chk("toggle_done",  32'(done),  32'd1);
    chk("toggle_sum",   32'(sum),   32'h27);
    chk("toggle_carry", 32'(carry), 32'd1);

    // Random traffic: sporadic Start requests and operands that change on every
    // cycle. Only the model comparator checks this traffic.
    repeat (1500) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      da    = W'($urandom);
      db    = W'($urandom);
    end
    start = 1'b0;
    repeat (12) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
